// File: rtl/id_ex_stage_if.sv
// Bus between decode, the ID/EX register and the forwarding sources.
// master = decode/pipeline side, slave = the id_ex_stage register.
interface id_ex_stage_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CTRL_W = 3
);
  logic              id_valid;
  logic [DATA_W-1:0] id_rs_data;
  logic [DATA_W-1:0] id_rt_data;
  logic [DATA_W-1:0] id_imm;
  logic              id_alu_src;
  logic [CTRL_W-1:0] id_alu_ctrl;
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic [REG_AW-1:0] id_rd;
  logic              id_reg_write;
  logic              id_mem_read;
  logic              id_mem_write;
  logic              stall;
  logic              flush;
  logic              exmem_reg_write;
  logic [REG_AW-1:0] exmem_rd;
  logic [DATA_W-1:0] exmem_result;
  logic              memwb_reg_write;
  logic [REG_AW-1:0] memwb_rd;
  logic [DATA_W-1:0] memwb_result;
  logic              hazard_stall;
  logic              ex_valid;
  logic [DATA_W-1:0] ex_a;
  logic [DATA_W-1:0] ex_b;
  logic [CTRL_W-1:0] ex_alu_ctrl;
  logic [DATA_W-1:0] ex_store_data;
  logic [REG_AW-1:0] ex_rd;
  logic              ex_reg_write;
  logic              ex_mem_read;
  logic              ex_mem_write;

  modport master (
    output id_valid, id_rs_data, id_rt_data, id_imm, id_alu_src, id_alu_ctrl,
           id_rs, id_rt, id_rd, id_reg_write, id_mem_read, id_mem_write,
           stall, flush, exmem_reg_write, exmem_rd, exmem_result,
           memwb_reg_write, memwb_rd, memwb_result,
    input  hazard_stall, ex_valid, ex_a, ex_b, ex_alu_ctrl, ex_store_data,
           ex_rd, ex_reg_write, ex_mem_read, ex_mem_write
  );

  modport slave (
    input  id_valid, id_rs_data, id_rt_data, id_imm, id_alu_src, id_alu_ctrl,
           id_rs, id_rt, id_rd, id_reg_write, id_mem_read, id_mem_write,
           stall, flush, exmem_reg_write, exmem_rd, exmem_result,
           memwb_reg_write, memwb_rd, memwb_result,
    output hazard_stall, ex_valid, ex_a, ex_b, ex_alu_ctrl, ex_store_data,
           ex_rd, ex_reg_write, ex_mem_read, ex_mem_write
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX/MEM + MEM/WB operand forwarding and hazard detection.
// Define ID_EX_FWD_EN to build the forwarding muxes; otherwise RAW hazards stall instead.
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CTRL_W = 3
) (
  input logic         clk,
  input logic         reset,
  id_ex_stage_if.slave bus
);

  logic              r_valid;
  logic [DATA_W-1:0] r_rs_data;
  logic [DATA_W-1:0] r_rt_data;
  logic [DATA_W-1:0] r_imm;
  logic              r_alu_src;
  logic [CTRL_W-1:0] r_alu_ctrl;
  logic [REG_AW-1:0] r_rs;
  logic [REG_AW-1:0] r_rt;
  logic [REG_AW-1:0] r_rd;
  logic              r_reg_write;
  logic              r_mem_read;
  logic              r_mem_write;

  logic              w_hazard;
  logic              w_rs_match_ex;
  logic              w_rt_match_ex;
  logic [DATA_W-1:0] w_fwd_rs;
  logic [DATA_W-1:0] w_fwd_rt;

  // NOTE: every pipeline register, data included, is async-cleared so outputs read 0 during reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_valid     <= 1'b0;
      r_rs_data   <= '0;
      r_rt_data   <= '0;
      r_imm       <= '0;
      r_alu_src   <= 1'b0;
      r_alu_ctrl  <= '0;
      r_rs        <= '0;
      r_rt        <= '0;
      r_rd        <= '0;
      r_reg_write <= 1'b0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
    end else if (bus.flush || (!bus.stall && w_hazard)) begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      r_valid     <= 1'b0;
      r_alu_src   <= 1'b0;
      r_alu_ctrl  <= '0;
      r_reg_write <= 1'b0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
    end else if (!bus.stall) begin
      r_valid     <= bus.id_valid;
      r_rs_data   <= bus.id_rs_data;
      r_rt_data   <= bus.id_rt_data;
      r_imm       <= bus.id_imm;
      r_alu_src   <= bus.id_alu_src;
      r_alu_ctrl  <= bus.id_alu_ctrl;
      r_rs        <= bus.id_rs;
      r_rt        <= bus.id_rt;
      r_rd        <= bus.id_rd;
      r_reg_write <= bus.id_reg_write;
      r_mem_read  <= bus.id_mem_read;
      r_mem_write <= bus.id_mem_write;
    end
  end

  // Decode sources compared against the instruction currently in EX.
  assign w_rs_match_ex = (r_rd != '0) && (r_rd == bus.id_rs);
  assign w_rt_match_ex = (r_rd != '0) && (r_rd == bus.id_rt) && !bus.id_alu_src;

`ifdef ID_EX_FWD_EN
  always_comb begin
    // NOTE: defaults first so no path through the mux can infer a latch.
    w_fwd_rs = r_rs_data;
    w_fwd_rt = r_rt_data;
    if (bus.exmem_reg_write && bus.exmem_rd != '0 && bus.exmem_rd == r_rs)
      w_fwd_rs = bus.exmem_result;
    else if (bus.memwb_reg_write && bus.memwb_rd != '0 && bus.memwb_rd == r_rs)
      w_fwd_rs = bus.memwb_result;
    if (bus.exmem_reg_write && bus.exmem_rd != '0 && bus.exmem_rd == r_rt)
      w_fwd_rt = bus.exmem_result;
    else if (bus.memwb_reg_write && bus.memwb_rd != '0 && bus.memwb_rd == r_rt)
      w_fwd_rt = bus.memwb_result;
  end

  assign w_hazard = bus.id_valid && r_valid && r_mem_read &&
                    (w_rs_match_ex || w_rt_match_ex);
`else
  logic w_mem_match;
  logic w_unused;

  assign w_fwd_rs = r_rs_data;
  assign w_fwd_rt = r_rt_data;

  // Without forwarding any valid EX writer or EX/MEM writer blocks a dependent decode.
  assign w_mem_match = bus.exmem_reg_write && (bus.exmem_rd != '0) &&
                       ((bus.exmem_rd == bus.id_rs) ||
                        ((bus.exmem_rd == bus.id_rt) && !bus.id_alu_src));
  assign w_hazard = bus.id_valid &&
                    ((r_valid && (r_mem_read || r_reg_write) &&
                      (w_rs_match_ex || w_rt_match_ex)) || w_mem_match);

  assign w_unused = ^{r_rs, r_rt, bus.exmem_result, bus.memwb_reg_write,
                      bus.memwb_rd, bus.memwb_result};
`endif

  assign bus.hazard_stall  = w_hazard;
  assign bus.ex_valid      = r_valid;
  assign bus.ex_a          = w_fwd_rs;
  assign bus.ex_b          = r_alu_src ? r_imm : w_fwd_rt;
  assign bus.ex_store_data = w_fwd_rt;
  assign bus.ex_alu_ctrl   = r_alu_ctrl;
  assign bus.ex_rd         = r_rd;
  assign bus.ex_reg_write  = r_valid && r_reg_write;
  assign bus.ex_mem_read   = r_valid && r_mem_read;
  assign bus.ex_mem_write  = r_valid && r_mem_write;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage; expectations follow whether ID_EX_FWD_EN is defined.
module tb_id_ex_stage;

  typedef struct packed {
    logic        v;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] sd;
    logic [2:0]  ctrl;
    logic [4:0]  rd;
    logic        rw;
    logic        mr;
    logic        mw;
  } ex_t;

  logic clk;
  logic reset;
  int   total = 0;
  int   bad   = 0;
  ex_t  exp_q[$];

  id_ex_stage_if #(.DATA_W(32), .REG_AW(5), .CTRL_W(3)) bus ();

  id_ex_stage #(.DATA_W(32), .REG_AW(5), .CTRL_W(3)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected finish");
    $fatal(1, "watchdog");
  end

  function automatic ex_t sample();
    return '{bus.ex_valid, bus.ex_a, bus.ex_b, bus.ex_store_data, bus.ex_alu_ctrl,
             bus.ex_rd, bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write};
  endfunction

  // Expected EX contents one cycle after a load, with no writer forwarding.
  function automatic ex_t model(input logic v, input logic [31:0] rsd, input logic [31:0] rtd,
                                input logic [31:0] imm, input logic src, input logic [2:0] ctrl,
                                input logic [4:0] rd, input logic rw, input logic mr, input logic mw);
    return '{v, rsd, (src ? imm : rtd), rtd, ctrl, rd, rw & v, mr & v, mw & v};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.id_valid = 0; bus.id_rs_data = 0; bus.id_rt_data = 0; bus.id_imm = 0;
    bus.id_alu_src = 0; bus.id_alu_ctrl = 0; bus.id_rs = 0; bus.id_rt = 0; bus.id_rd = 0;
    bus.id_reg_write = 0; bus.id_mem_read = 0; bus.id_mem_write = 0;
    bus.stall = 0; bus.flush = 0;
    bus.exmem_reg_write = 0; bus.exmem_rd = 0; bus.exmem_result = 0;
    bus.memwb_reg_write = 0; bus.memwb_rd = 0; bus.memwb_result = 0;
  endtask

  task automatic drive(input logic v, input logic [4:0] rs, input logic [31:0] rsd,
                       input logic [4:0] rt, input logic [31:0] rtd, input logic [31:0] imm,
                       input logic src, input logic [2:0] ctrl, input logic [4:0] rd,
                       input logic rw, input logic mr, input logic mw);
    bus.id_valid = v; bus.id_rs = rs; bus.id_rs_data = rsd; bus.id_rt = rt;
    bus.id_rt_data = rtd; bus.id_imm = imm; bus.id_alu_src = src; bus.id_alu_ctrl = ctrl;
    bus.id_rd = rd; bus.id_reg_write = rw; bus.id_mem_read = mr; bus.id_mem_write = mw;
  endtask

  task automatic issue(input logic v, input logic [4:0] rs, input logic [31:0] rsd,
                       input logic [4:0] rt, input logic [31:0] rtd, input logic [31:0] imm,
                       input logic src, input logic [2:0] ctrl, input logic [4:0] rd,
                       input logic rw, input logic mr, input logic mw);
    drive(v, rs, rsd, rt, rtd, imm, src, ctrl, rd, rw, mr, mw);
    exp_q.push_back(model(v, rsd, rtd, imm, src, ctrl, rd, rw, mr, mw));
  endtask

  task automatic test_reset();
    ex_t got;
    reset = 1'b0;
    idle();
    #1;
    got = sample(); total++;
    if (got !== ex_t'(0)) begin
      bad++; $display("FAIL reset_state: got %h expected 0", got);
    end
    #3 reset = 1'b1;
    drive(1, 5'd1, 32'h1234, 5'd2, 32'h5678, 32'h0, 0, 3'd4, 5'd25, 1, 0, 0);
    tick();
    total++;
    if (bus.ex_valid !== 1'b1) begin
      bad++; $display("FAIL reset_pre_load: ex_valid got %b expected 1", bus.ex_valid);
    end
    #2 reset = 1'b0;
    #1;
    got = sample(); total++;
    if (got !== ex_t'(0)) begin
      bad++; $display("FAIL reset_async: got %h expected 0", got);
    end
    reset = 1'b1;
    tick();
    got = sample(); total++;
    if (got !== model(1, 32'h1234, 32'h5678, 32'h0, 0, 3'd4, 5'd25, 1, 0, 0)) begin
      bad++; $display("FAIL reset_first_load: got %h", got);
    end
    idle();
    tick();
  endtask

  task automatic test_basic();
    ex_t got, exp;
    issue(1, 5'd3, 32'd5, 5'd4, 32'd7, 32'h0, 0, 3'd2, 5'd20, 1, 0, 0);
    tick(); exp = exp_q.pop_front(); got = sample(); total++;
    if (got !== exp) begin bad++; $display("FAIL basic_alu: got %h expected %h", got, exp); end
    issue(1, 5'd1, 32'h11, 5'd2, 32'h22, 32'h100, 1, 3'd3, 5'd21, 1, 0, 0);
    tick(); exp = exp_q.pop_front(); got = sample(); total++;
    if (got !== exp) begin bad++; $display("FAIL basic_imm: got %h expected %h", got, exp); end
    issue(0, 5'd7, 32'h77, 5'd8, 32'h88, 32'h9, 0, 3'd6, 5'd22, 1, 1, 1);
    tick(); exp = exp_q.pop_front(); got = sample(); total++;
    if (got !== exp) begin bad++; $display("FAIL basic_invalid: got %h expected %h", got, exp); end
    issue(1, 5'd5, 32'h1000, 5'd6, 32'hDEAD, 32'h8, 1, 3'd0, 5'd0, 0, 0, 1);
    tick(); exp = exp_q.pop_front(); got = sample(); total++;
    if (got !== exp) begin bad++; $display("FAIL basic_store: got %h expected %h", got, exp); end
    for (int i = 0; i < 6; i++) begin
      issue(1, 5'($urandom_range(1, 15)), $urandom, 5'($urandom_range(1, 15)), $urandom,
            $urandom, 1'($urandom), 3'($urandom), 5'($urandom_range(16, 31)),
            1'($urandom), 1'b0, 1'($urandom));
      tick(); exp = exp_q.pop_front(); got = sample(); total++;
      if (got !== exp) begin bad++; $display("FAIL basic_rand%0d: got %h expected %h", i, got, exp); end
    end
    idle();
    tick();
  endtask

  task automatic test_forward();
    logic [31:0] exp_a, exp_b;
    drive(1, 5'd3, 32'h11, 5'd4, 32'h44, 32'h0, 0, 3'd1, 5'd20, 1, 0, 0);
    tick();
    idle();
    bus.exmem_reg_write = 1; bus.exmem_rd = 5'd3; bus.exmem_result = 32'hAA;
    bus.memwb_reg_write = 1; bus.memwb_rd = 5'd3; bus.memwb_result = 32'hBB;
    #1;
`ifdef ID_EX_FWD_EN
    exp_a = 32'hAA;
`else
    exp_a = 32'h11;
`endif
    total++;
    if (bus.ex_a !== exp_a) begin bad++; $display("FAIL fwd_both: ex_a got %h expected %h", bus.ex_a, exp_a); end
    bus.exmem_reg_write = 0;
    #1;
`ifdef ID_EX_FWD_EN
    exp_a = 32'hBB;
`endif
    total++;
    if (bus.ex_a !== exp_a) begin bad++; $display("FAIL fwd_memwb: ex_a got %h expected %h", bus.ex_a, exp_a); end
    bus.exmem_reg_write = 1; bus.exmem_rd = 5'd0; bus.exmem_result = 32'hCC;
    bus.memwb_rd = 5'd0; bus.memwb_result = 32'hCC;
    #1;
    total++;
    if (bus.ex_a !== 32'h11) begin bad++; $display("FAIL fwd_rd0: ex_a got %h expected 11", bus.ex_a); end
    bus.exmem_rd = 5'd4; bus.exmem_result = 32'h99;
    #1;
`ifdef ID_EX_FWD_EN
    exp_b = 32'h99;
`else
    exp_b = 32'h44;
`endif
    total++;
    if (bus.ex_b !== exp_b || bus.ex_store_data !== exp_b) begin
      bad++; $display("FAIL fwd_rt: ex_b %h store %h expected %h", bus.ex_b, bus.ex_store_data, exp_b);
    end
    idle();
    tick();
  endtask

  task automatic test_load_use();
    logic [31:0] exp_a;
    drive(1, 5'd1, 32'h1, 5'd2, 32'h2, 32'h40, 1, 3'd2, 5'd6, 1, 1, 0);
    tick();
    drive(1, 5'd1, 32'h3, 5'd6, 32'h4, 32'h5, 1, 3'd1, 5'd22, 1, 0, 0);
    #1; total++;
    if (bus.hazard_stall !== 1'b0) begin bad++; $display("FAIL lu_rt_imm: hazard got %b expected 0", bus.hazard_stall); end
    drive(1, 5'd6, 32'h55, 5'd7, 32'h70, 32'h0, 0, 3'd1, 5'd22, 1, 0, 0);
    #1; total++;
    if (bus.hazard_stall !== 1'b1) begin bad++; $display("FAIL lu_detect: hazard got %b expected 1", bus.hazard_stall); end
    tick(); total++;
    if (bus.ex_valid !== 1'b0 || bus.ex_reg_write !== 1'b0) begin
      bad++; $display("FAIL lu_bubble: ex_valid %b reg_write %b expected 0 0", bus.ex_valid, bus.ex_reg_write);
    end
    total++;
    if (bus.hazard_stall !== 1'b0) begin bad++; $display("FAIL lu_clear: hazard got %b expected 0", bus.hazard_stall); end
`ifndef ID_EX_FWD_EN
    bus.exmem_reg_write = 1; bus.exmem_rd = 5'd6;
    #1; total++;
    if (bus.hazard_stall !== 1'b1) begin bad++; $display("FAIL lu_exmem_raw: hazard got %b expected 1", bus.hazard_stall); end
    bus.exmem_reg_write = 0; bus.exmem_rd = 5'd0;
`endif
    bus.memwb_reg_write = 1; bus.memwb_rd = 5'd6; bus.memwb_result = 32'h66;
    tick();
`ifdef ID_EX_FWD_EN
    exp_a = 32'h66;
`else
    exp_a = 32'h55;
`endif
    total++;
    if (bus.ex_valid !== 1'b1 || bus.ex_a !== exp_a) begin
      bad++; $display("FAIL lu_reload: ex_valid %b ex_a %h expected 1 %h", bus.ex_valid, bus.ex_a, exp_a);
    end
    idle();
    tick();
  endtask

  task automatic test_stall_flush();
    ex_t got, exp;
    issue(1, 5'd2, 32'h12, 5'd3, 32'h34, 32'h0, 0, 3'd5, 5'd23, 1, 0, 0);
    tick(); exp = exp_q.pop_front(); got = sample(); total++;
    if (got !== exp) begin bad++; $display("FAIL stall_load: got %h expected %h", got, exp); end
    bus.stall = 1;
    for (int i = 0; i < 3; i++) begin
      drive(1, 5'(i + 8), 32'hF0 + i, 5'd9, 32'hE0 + i, 32'h7, 1'(i), 3'd7, 5'd24, 0, 1, 1);
      tick(); got = sample(); total++;
      if (got !== exp) begin bad++; $display("FAIL stall_hold%0d: got %h expected %h", i, got, exp); end
    end
    bus.flush = 1;
    tick(); total++;
    if (bus.ex_valid !== 1'b0 || bus.ex_reg_write !== 1'b0 || bus.ex_alu_ctrl !== 3'd0) begin
      bad++; $display("FAIL flush_over_stall: valid %b rw %b ctrl %0d expected 0 0 0",
                      bus.ex_valid, bus.ex_reg_write, bus.ex_alu_ctrl);
    end
    idle();
    tick();
  endtask

  task automatic test_alu_raw();
    logic exp_h;
    drive(1, 5'd1, 32'h1, 5'd2, 32'h2, 32'h0, 0, 3'd0, 5'd5, 1, 0, 0);
    tick();
    drive(1, 5'd1, 32'h1, 5'd5, 32'h2, 32'h3, 0, 3'd0, 5'd26, 1, 0, 0);
    #1;
`ifdef ID_EX_FWD_EN
    exp_h = 1'b0;
`else
    exp_h = 1'b1;
`endif
    total++;
    if (bus.hazard_stall !== exp_h) begin bad++; $display("FAIL raw_rt: hazard got %b expected %b", bus.hazard_stall, exp_h); end
    bus.id_alu_src = 1;
    #1; total++;
    if (bus.hazard_stall !== 1'b0) begin bad++; $display("FAIL raw_rt_imm: hazard got %b expected 0", bus.hazard_stall); end
    drive(1, 5'd1, 32'h1, 5'd2, 32'h2, 32'h0, 0, 3'd0, 5'd0, 1, 1, 0);
    tick();
    drive(1, 5'd0, 32'h0, 5'd0, 32'h0, 32'h0, 0, 3'd0, 5'd27, 1, 0, 0);
    #1; total++;
    if (bus.hazard_stall !== 1'b0) begin bad++; $display("FAIL raw_r0: hazard got %b expected 0", bus.hazard_stall); end
    idle();
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_forward();
    test_load_use();
    test_stall_flush();
    test_alu_raw();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
